// File: rtl/mux_4to1_if.sv
// Bus bundle for mux_4to1: packed lanes, lane index, capture enable and outputs.
interface mux_4to1_if #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned N_IN   = 4
);
  localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN*DATA_W-1:0] in;
  logic [SEL_W-1:0]       sel;
  logic                   en;
  logic [DATA_W-1:0]      y;
  logic [DATA_W-1:0]      y_q;
  logic                   y_q_valid;

  modport master (output in, sel, en, input y, y_q, y_q_valid);
  modport slave  (input in, sel, en, output y, y_q, y_q_valid);
endinterface

// File: rtl/mux_4to1.sv
// N-to-1 lane selector with combinational output and an enable-gated registered copy.
// DATA_W/N_IN must match the parameters of the connected mux_4to1_if instance.
module mux_4to1 #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned N_IN   = 4
) (
  input logic        clk,
  input logic        rst,
  mux_4to1_if.slave  bus
);
  logic [31:0]       sel_ext;
  logic [DATA_W-1:0] y_sel;
  logic [DATA_W-1:0] y_cap_d, y_cap_q;
  logic              valid_d, valid_q;

  assign sel_ext = 32'(bus.sel);

  // Select lane[sel]; only the matching lane is read, out-of-range indices give zero.
  always_comb begin
    y_sel = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel_ext == k) y_sel = bus.in[k*DATA_W +: DATA_W];
    end
  end

  // Capture on en=1; an unknown en falls through the if and holds.
  always_comb begin
    y_cap_d = y_cap_q;
    valid_d = valid_q;
    if (bus.en) begin
      y_cap_d = y_sel;
      valid_d = 1'b1;
    end
  end

  // Registered copy, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_cap_q <= '0;
      valid_q <= 1'b0;
    end else begin
      y_cap_q <= y_cap_d;
      valid_q <= valid_d;
    end
  end

  assign bus.y         = y_sel;
  assign bus.y_q       = y_cap_q;
  assign bus.y_q_valid = valid_q;
endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: default 1x4 instance and an 8-bit x3 instance.
module tb_mux_4to1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   clk_run = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] ea_yq, eb_yq;
  logic        ea_v, eb_v;

  mux_4to1_if #(.DATA_W(1), .N_IN(4)) ia ();
  mux_4to1_if #(.DATA_W(8), .N_IN(3)) ib ();

  mux_4to1 #(.DATA_W(1), .N_IN(4)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mux_4to1 #(.DATA_W(8), .N_IN(3)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  always #5 if (clk_run) clk = ~clk;

  // Reference: lane s of a packed word, zero when s is out of range.
  function automatic logic [31:0] ref_mux(logic [31:0] v, int unsigned s,
                                          int unsigned dw, int unsigned n);
    logic [31:0] mask;
    mask = (32'd1 << dw) - 32'd1;
    if (s >= n) return '0;
    return (v >> (s * dw)) & mask;
  endfunction

  function automatic logic [31:0] ref_a();
    return ref_mux(32'(ia.in), int'(ia.sel), 1, 4);
  endfunction

  function automatic logic [31:0] ref_b();
    return ref_mux(32'(ib.in), int'(ib.sel), 8, 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag);
    chk({tag, ".a.y"}, 32'(ia.y), ref_a());
    chk({tag, ".b.y"}, 32'(ib.y), ref_b());
  endtask

  task automatic chk_reg(input string tag);
    chk({tag, ".a.y_q"}, 32'(ia.y_q), ea_yq);
    chk({tag, ".a.vld"}, 32'(ia.y_q_valid), 32'(ea_v));
    chk({tag, ".b.y_q"}, 32'(ib.y_q), eb_yq);
    chk({tag, ".b.vld"}, 32'(ib.y_q_valid), 32'(eb_v));
  endtask

  // One rising edge; the model captures the pre-edge selection when en is a clean 1.
  task automatic tick();
    if (rst === 1'b0) begin
      if (ia.en === 1'b1) begin ea_yq = ref_a(); ea_v = 1'b1; end
      if (ib.en === 1'b1) begin eb_yq = ref_b(); eb_v = 1'b1; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ea_yq = '0; eb_yq = '0; ea_v = 1'b0; eb_v = 1'b0;
    ia.en = 1'b0; ib.en = 1'b0;
    ib.in = 24'hC3_5A_A5;

    // Combinational sweeps with no clock activity.
    ia.in = 4'b1010;
    for (int unsigned s = 0; s < 4; s++) begin
      ia.sel = 2'(s); ib.sel = 2'(s); #10;
      chk_y("sweep1010");
      chk("sweep1010.exp", 32'(ia.y), 32'(s & 1));
    end
    ia.in = 4'b0101;
    for (int unsigned s = 0; s < 4; s++) begin
      ia.sel = 2'(s); #10;
      chk("sweep0101", 32'(ia.y), 32'((s + 1) & 1));
    end
    ia.in = 4'b1111;
    for (int unsigned s = 0; s < 4; s++) begin
      ia.sel = 2'(s); #10; chk("sweep1111", 32'(ia.y), 32'd1);
    end
    ia.in = 4'b0000;
    for (int unsigned s = 0; s < 4; s++) begin
      ia.sel = 2'(s); #10; chk("sweep0000", 32'(ia.y), 32'd0);
    end

    // Wide instance: lane 2 and the out-of-range index.
    ib.sel = 2'd2; #1; chk("b.sel2", 32'(ib.y), 32'hC3);
    ib.sel = 2'd3; #1; chk("b.sel3", 32'(ib.y), 32'h00);
    ib.in = 24'h12_34_56; ib.sel = 2'd0; #1; chk("b.sel0", 32'(ib.y), 32'h56);

    // Reset without any clock.
    rst = 1'b1; #3;
    ea_yq = '0; eb_yq = '0; ea_v = 1'b0; eb_v = 1'b0;
    chk_reg("rst_noclk");
    rst = 1'b0; #3;
    chk_reg("post_rst");

    clk_run = 1'b1;
    @(negedge clk);
    ia.in = 4'b1010; ia.sel = 2'b01; ia.en = 1'b1;
    ib.sel = 2'd1; ib.en = 1'b1;
    tick(); chk_reg("cap1");
    chk("cap1.lit", 32'(ia.y_q), 32'd1);
    ia.sel = 2'b10;
    tick(); chk_reg("cap2");
    chk("cap2.lit", 32'(ia.y_q), 32'd0);
    ia.sel = 2'b01;
    tick(); chk_reg("cap3");

    // Enable hold while y follows in[0].
    ia.en = 1'b0; ib.en = 1'b0; ia.sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      ia.in = 4'(i + 3);
      ib.in = 24'(32'h010203 * (i + 1));
      tick(); chk_reg("hold"); chk_y("hold");
      chk("hold.lit", 32'(ia.y_q), 32'd1);
    end

    // Unknown enable behaves as hold.
    ia.en = 1'bx; ib.en = 1'bx; ia.sel = 2'b10; ia.in = 4'b0000;
    tick(); chk_reg("en_x"); chk_y("en_x");
    ia.en = 1'b1; ib.en = 1'b1; ia.sel = 2'b01; ia.in = 4'b0010;
    tick(); chk_reg("recap");

    // Async reset between edges; y keeps tracking.
    @(negedge clk);
    rst = 1'b1; #1;
    ea_yq = '0; eb_yq = '0; ea_v = 1'b0; eb_v = 1'b0;
    chk_reg("async_rst"); chk_y("async_rst");
    ia.in = 4'b1101; ia.sel = 2'b11;
    tick(); chk_reg("rst_wins"); chk_y("rst_wins");
    rst = 1'b0;

    // Randomized traffic against the reference.
    for (int i = 0; i < 200; i++) begin
      ia.in = 4'($urandom); ia.sel = 2'($urandom);
      ib.in = 24'($urandom); ib.sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       ia.en = 1'bx;
        1, 2:    ia.en = 1'b0;
        default: ia.en = 1'b1;
      endcase
      ib.en = 1'($urandom);
      #1; chk_y("rnd");
      tick(); chk_reg("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
